dmux8way16_buf: RTL and testbench
=================================

# dmux8way16_buf

Registered 1-to-8 demultiplexer for 16-bit words with a valid/ready handshake on every port. A single producer steers each word to one of eight consumer channels, or broadcasts it to all eight. Each channel holds one buffered word until its consumer accepts it. The block is the distribution counterpart of the 8-way 16-bit selector and fans a shared datapath out to eight sinks.

## Interface
- `WIDTH`, default 16: data word width; the ways are fixed at 8.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `in_valid`  in  1  producer has a word on `in_data`.
- `in_ready`  out  1  block accepts the word this cycle.
- `in_data`  in  WIDTH  word to distribute.
- `in_sel`  in  3  destination channel 0..7; ignored when `in_bcast`=1.
- `in_bcast`  in  1  deliver the word to all 8 channels.
- `out_valid`  out  8  bit k high while channel k holds a word.
- `out_ready`  in  8  bit k high when consumer k takes the word.
- `out_data`  out  8*WIDTH  channel k word on bits [WIDTH*k+WIDTH-1 : WIDTH*k].
- `out_count`  out  4  number of channels currently holding a word (0..8).

## Operation
- Per channel k: a `valid_k` flag and a `data_k` register.
- `free_k` = !`valid_k` | `out_ready[k]`. The channel is empty, or is emptying this cycle.
- `in_ready`:
  - unicast: `free_k` with k=`in_sel`;
  - broadcast: AND of all `free_k`.
  - The path from `out_ready` to `in_ready` is combinational. `in_ready` must not depend on `in_valid`.
- `accept` = `in_valid` & `in_ready`.
- `load_k` = `accept` & (`in_bcast` | `in_sel`==k).
- Channel update each edge, in priority order:
  - `reset`: `valid_k` <= 0. `data_k` is unchanged (don't-care).
  - `load_k`: `data_k` <= `in_data`, `valid_k` <= 1. This covers a consumer pop in the same cycle: the pop and the load happen together and the channel stays full with the new word.
  - `valid_k` & `out_ready[k]`: `valid_k` <= 0.
  - Otherwise: hold.
- `out_valid[k]` = `valid_k`; `out_data` slice k = `data_k`.
- `out_ready[k]` while `valid_k`=0 is ignored. No state change, no error.
- `out_count` = popcount of `valid_k`. It is registered and updated on the same edge as the flags, so it always equals popcount(`out_valid`).
- Broadcast is all-or-nothing. The word is never written to only some channels.
- No reordering or dropping. Each accepted word reaches every addressed channel exactly once.
- `in_sel` values are all legal; no error condition exists.

## Timing
- Reset values: `out_valid`=8'h00, `out_count`=0, `in_ready`=1 (all channels free).
- `out_data` after reset is undefined until a channel's first load.
- Latency: word accepted at edge N gives `out_valid[k]`=1 and valid `out_data` slice k from edge N onward, i.e. visible in cycle N+1.
- Throughput: 1 word/cycle sustained to any channel whose consumer holds `out_ready`=1.
- Stability: while `out_valid[k]`=1 and `out_ready[k]`=0, slice k of `out_data` is held constant.
- Back-pressure:
  - A full channel with `out_ready`=0 stalls only words addressed to it.
  - Any such channel stalls all broadcasts.
- Reset mid-operation: all buffered words are discarded on the reset edge. `in_ready`=1 from the following cycle.
- Input protocol: the producer may change `in_data`/`in_sel`/`in_bcast` freely while `in_valid`=0. No hold requirement exists after a stall, because the block samples only on `accept`.

## Test plan
- **Reset check:** assert `reset` for 2 cycles with `out_ready`=8'h00. Require `out_valid`=8'h00, `out_count`=0 and `in_ready`=1.
- **Unicast fill:** send `in_data`=16'h1000+k, `in_sel`=k for k=0..7 on consecutive cycles with `out_ready`=0.
  - Require `out_valid`=8'hFF and `out_count`=8.
  - Require each slice k = 16'h1000+k.
  - A ninth word to `in_sel`=3 sees `in_ready`=0.
- **Simultaneous pop and load:** with channel 3 full (16'hAAAA), set `out_ready[3]`=1 and send 16'hBBBB to `in_sel`=3 in the same cycle.
  - Require `in_ready`=1.
  - Next cycle: `out_valid[3]`=1, slice 3 = 16'hBBBB, `out_count` unchanged.
- **Broadcast blocked:** with channel 5 full and `out_ready[5]`=0, request broadcast of 16'hC0DE.
  - Require `in_ready`=0 and no channel changes.
  - Raise `out_ready[5]`: require acceptance, then all slices = 16'hC0DE and `out_valid`=8'hFF.
- **Streaming:** with `out_ready[2]`=1, stream 16 words 0..15 to `in_sel`=2 back-to-back.
  - Require `in_ready` high every cycle.
  - Slice 2 presents each value exactly one cycle after acceptance, in order.
- **Reset mid-operation:** with 4 channels full, pulse `reset` for 1 cycle while `in_valid`=1.
  - Require `out_valid`=0 and `out_count`=0 on the next cycle.
  - The input word is not loaded.

Source files
------------

// File: rtl/dmux8way16_buf.sv
// rtl/dmux8way16_buf.sv - registered 1-to-8 word demultiplexer with per-channel one-word buffers
//
// Purpose:
//   Steers each producer word to one of eight consumer channels (in_sel) or
//   broadcasts it to all eight (in_bcast). Each channel buffers one word and
//   presents it until its consumer accepts it with a valid/ready handshake.
//
// Ports:
//   clk        single clock, all state on the rising edge
//   reset      synchronous active-high reset
//   in_valid   producer has a word on in_data
//   in_ready   block accepts the word this cycle (independent of in_valid)
//   in_data    word to distribute
//   in_sel     destination channel, ignored for broadcast
//   in_bcast   deliver the word to all eight channels
//   out_valid  bit k set while channel k holds a word
//   out_ready  bit k set when consumer k takes its word
//   out_data   channel k word on bits [WIDTH*k +: WIDTH]
//   out_count  number of channels currently holding a word

module dmux8way16_buf #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [2:0]         in_sel,
    input  logic               in_bcast,
    output logic [7:0]         out_valid,
    input  logic [7:0]         out_ready,
    output logic [8*WIDTH-1:0] out_data,
    output logic [3:0]         out_count
);

    logic [7:0]       valid_q;
    logic [WIDTH-1:0] data_q [8];
    logic [3:0]       count_q;

    logic [7:0]       free;
    logic             accept;
    logic [7:0]       load;
    logic [7:0]       valid_next;
    logic [3:0]       count_next;

    // A channel can take a word if it is empty or its consumer is draining it
    // on this same edge, so out_ready feeds in_ready combinationally.
    assign free = ~valid_q | out_ready;

    // Broadcast is all-or-nothing: it needs every channel free at once.
    always_comb begin
        in_ready = free[in_sel];
        if (in_bcast) begin
            in_ready = &free;
        end
    end

    assign accept = in_valid & in_ready;

    always_comb begin
        load = 8'h00;
        if (accept) begin
            if (in_bcast) begin
                load = 8'hFF;
            end else begin
                load[in_sel] = 1'b1;
            end
        end
    end

    // Load wins over pop, so a simultaneous pop and load leaves the channel
    // full with the new word. out_ready on an empty channel has no effect.
    assign valid_next = load | (valid_q & ~out_ready);

    always_comb begin
        count_next = 4'd0;
        for (int k = 0; k < 8; k++) begin
            count_next = count_next + {3'b000, valid_next[k]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 8'h00;
            count_q <= 4'd0;
        end else begin
            valid_q <= valid_next;
            count_q <= count_next;
        end
    end

    // Data registers carry no reset; their content only matters while the
    // matching valid flag is set.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 8; k++) begin
            if (load[k] && !reset) begin
                data_q[k] <= in_data;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_count = count_q;

    for (genvar g = 0; g < 8; g++) begin : g_out
        assign out_data[WIDTH*g +: WIDTH] = data_q[g];
    end

endmodule

// File: tb/tb_dmux8way16_buf.sv
// tb/tb_dmux8way16_buf.sv - scoreboard bench for dmux8way16_buf

module tb_dmux8way16_buf;

    localparam int WIDTH = 16;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data = '0;
    logic [2:0]         in_sel = 3'd0;
    logic               in_bcast = 1'b0;
    logic [7:0]         out_valid;
    logic [7:0]         out_ready = 8'h00;
    logic [8*WIDTH-1:0] out_data;
    logic [3:0]         out_count;

    dmux8way16_buf #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_bcast  (in_bcast),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit armed = 1'b0;

    // Expected contents of each channel, oldest word first.
    logic [WIDTH-1:0] exp_q [8][$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: mid-cycle compare of all outputs against the queues; a channel
    // whose consumer is ready completes its handshake, so its word is retired.
    logic [7:0] mon_mask;
    int         mon_cnt;
    always @(negedge clk) begin
        if (armed) begin
            mon_mask = 8'h00;
            mon_cnt  = 0;
            for (int k = 0; k < 8; k++) begin
                if (exp_q[k].size() != 0) begin
                    mon_mask[k] = 1'b1;
                    mon_cnt++;
                end
            end
            chk("out_valid", {24'd0, out_valid}, {24'd0, mon_mask});
            chk("out_count", {28'd0, out_count}, mon_cnt);
            for (int k = 0; k < 8; k++) begin
                if (mon_mask[k]) begin
                    chk($sformatf("out_data[%0d]", k), {16'd0, out_data[WIDTH*k +: WIDTH]},
                        {16'd0, exp_q[k][0]});
                    if (out_ready[k]) begin
                        void'(exp_q[k].pop_front());
                    end
                end
            end
        end
    end

    // One clock of stimulus. After the monitor has retired this cycle's pops,
    // a channel is free exactly when its queue is empty.
    task automatic cyc(input bit rst, input bit v, input logic [WIDTH-1:0] d,
                       input logic [2:0] s, input bit b, input logic [7:0] ordy,
                       input int exp_rdy);
        bit exp;
        @(posedge clk);
        #1;
        reset     = rst;
        in_valid  = v;
        in_data   = d;
        in_sel    = s;
        in_bcast  = b;
        out_ready = ordy;
        @(negedge clk);
        #1;
        if (b) begin
            exp = 1'b1;
            for (int k = 0; k < 8; k++) begin
                if (exp_q[k].size() != 0) exp = 1'b0;
            end
        end else begin
            exp = (exp_q[s].size() == 0);
        end
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp});
        if (exp_rdy >= 0) begin
            chk("in_ready_directed", {31'd0, in_ready}, exp_rdy);
        end
        if (rst) begin
            for (int k = 0; k < 8; k++) exp_q[k].delete();
        end else if (v && exp) begin
            for (int k = 0; k < 8; k++) begin
                if (b || s == k[2:0]) exp_q[k].push_back(d);
            end
        end
    endtask

    task automatic idle(input logic [7:0] ordy);
        cyc(1'b0, 1'b0, '0, 3'd0, 1'b0, ordy, -1);
    endtask

    initial begin
        // Reset check
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        armed = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_out_valid", {24'd0, out_valid}, 32'h00);
        chk("reset_out_count", {28'd0, out_count}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

        // Unicast fill
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 1'b1, 16'h1000 + k[15:0], k[2:0], 1'b0, 8'h00, 1);
        end
        idle(8'h00);
        chk("fill_out_valid", {24'd0, out_valid}, 32'hFF);
        chk("fill_out_count", {28'd0, out_count}, 32'd8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("fill_slice%0d", k), {16'd0, out_data[WIDTH*k +: WIDTH]}, 32'h1000 + k);
        end
        cyc(1'b0, 1'b1, 16'h9999, 3'd3, 1'b0, 8'h00, 0);

        // Simultaneous pop and load on channel 3
        cyc(1'b0, 1'b1, 16'hAAAA, 3'd3, 1'b0, 8'h08, 1);
        cyc(1'b0, 1'b1, 16'hBBBB, 3'd3, 1'b0, 8'h08, 1);
        idle(8'h00);
        chk("popload_valid3", {31'd0, out_valid[3]}, 32'd1);
        chk("popload_slice3", {16'd0, out_data[WIDTH*3 +: WIDTH]}, 32'hBBBB);
        chk("popload_count", {28'd0, out_count}, 32'd8);

        // Broadcast blocked by channel 5
        idle(8'hDF);
        cyc(1'b0, 1'b1, 16'hC0DE, 3'd0, 1'b1, 8'h00, 0);
        chk("bcast_blocked_valid", {24'd0, out_valid}, 32'h20);
        cyc(1'b0, 1'b1, 16'hC0DE, 3'd0, 1'b1, 8'h20, 1);
        idle(8'h00);
        chk("bcast_out_valid", {24'd0, out_valid}, 32'hFF);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("bcast_slice%0d", k), {16'd0, out_data[WIDTH*k +: WIDTH]}, 32'hC0DE);
        end

        // Streaming to channel 2
        idle(8'hFF);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, i[15:0], 3'd2, 1'b0, 8'h04, 1);
        end
        idle(8'h04);

        // Reset mid-operation
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b1, 16'h5000 + k[15:0], k[2:0], 1'b0, 8'h00, 1);
        end
        cyc(1'b1, 1'b1, 16'h7777, 3'd6, 1'b0, 8'h00, -1);
        idle(8'h00);
        chk("midreset_out_valid", {24'd0, out_valid}, 32'h00);
        chk("midreset_out_count", {28'd0, out_count}, 32'd0);
        chk("midreset_in_ready", {31'd0, in_ready}, 32'd1);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            cyc(($urandom % 100) == 0, ($urandom % 4) != 0, 16'($urandom),
                3'($urandom), ($urandom % 8) == 0, 8'($urandom), -1);
        end
        idle(8'hFF);
        idle(8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
